// File: rtl/spi_pkg.sv
// Shared types and default constants for the SPI master.
package spi_pkg;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_HALF_PERIOD = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: emits a one-cycle tick every HALF_PERIOD enabled cycles.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = SPI_HALF_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt;

  // Every FSM state change happens on tick, so clearing on tick restarts
  // the count at 0 in each new state.
  assign tick = enable && (cnt == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first: one byte out on mosi, one byte in from miso
// per accepted start, result returned with a single-cycle done strobe.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = SPI_HALF_PERIOD,
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  chip_select
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   tick;
  logic                   timer_en;

  assign timer_en = (state != IDLE);

  spi_clk_gen #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .enable(timer_en),
    .tick  (tick)
  );

  // NOTE: all state and outputs use non-blocking assignments so every
  // register updates from pre-edge values, keeping the outputs glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      chip_select <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      rx_data     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift    <= tx_data;
            bit_cnt     <= '0;
            mosi        <= tx_data[DATA_WIDTH-1];
            chip_select <= 1'b0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP, SHIFT_LO: begin
          if (tick) begin
            sclk     <= 1'b1;
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], miso};
            state    <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              state <= HOLD;
            end else begin
              // mosi moves only on the falling sclk edge.
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              mosi     <= tx_shift[DATA_WIDTH-2];
              state    <= SHIFT_LO;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            chip_select <= 1'b1;
            mosi        <= 1'b0;
            rx_data     <= rx_shift;
            done        <= 1'b1;
            state       <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single transfers plus hand-written
// corner sequences (held start, mid-transfer reset, HALF_PERIOD=1).
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sclk, mosi, miso, chip_select;
  logic [7:0] rx_data;
  logic       loop_en;
  logic       bus_bit;

  logic       start1;
  logic [7:0] tx1;
  logic       busy1, done1, sclk1, mosi1, cs1;
  logic [7:0] rx1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : bus_bit;

  spi_master #(.HALF_PERIOD(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso), .chip_select(chip_select)
  );

  spi_master #(.HALF_PERIOD(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1),
    .mosi(mosi1), .miso(mosi1), .chip_select(cs1)
  );

  typedef struct {
    logic [7:0] tx;
    bit         loop;
    logic [7:0] pat;
    logic [7:0] new_tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transfer on the H=4 instance, observed cycle by cycle from cycle 1.
  task automatic run_xfer(input vec_t v);
    int first_cs = -1, cs_rise = -1, done_cnt = 0, done_cyc = -1, busy_fall = -1;
    int rises = 0, bus_idx = 0;
    logic [7:0] mosi_byte = '0;
    logic [7:0] rx_at_done = '0;
    logic prev_sclk = 1'b0;
    loop_en = v.loop;
    bus_bit = v.pat[7];
    start   = 1'b1;
    tx_data = v.tx;
    next_cycle();
    start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (!chip_select && first_cs < 0) first_cs = cyc;
      if (chip_select && first_cs >= 0 && cs_rise < 0) cs_rise = cyc;
      if (done) begin
        done_cnt++;
        done_cyc   = cyc;
        rx_at_done = rx_data;
      end
      if (!busy && busy_fall < 0) busy_fall = cyc;
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_byte = {mosi_byte[6:0], mosi};
      end
      if (!sclk && prev_sclk) bus_idx++;
      if (bus_idx < 8) bus_bit = v.pat[7 - bus_idx];
      prev_sclk = sclk;
      if (cyc == 1) tx_data = v.new_tx;
      next_cycle();
    end
    check("cs_fall_cycle", first_cs, 1);
    check("cs_rise_cycle", cs_rise, 69);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, 69);
    check("rx_at_done", rx_at_done, v.exp_rx);
    check("rx_held", rx_data, v.exp_rx);
    check("busy_fall_cycle", busy_fall, 73);
    check("sclk_rises", rises, 8);
    check("mosi_byte", mosi_byte, v.exp_mosi);
    check("mosi_idle", mosi, 1'b0);
  endtask

  initial begin
    vec_t vecs[4];
    int done_cnt, done_cyc, rises, bad_tog, busy_fall;
    logic [7:0] mosi_byte;
    logic prev_sclk;

    vecs[0] = '{tx: 8'hA5, loop: 1'b1, pat: 8'h00, new_tx: 8'hA5, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    vecs[1] = '{tx: 8'hFF, loop: 1'b0, pat: 8'h3C, new_tx: 8'hFF, exp_rx: 8'h3C, exp_mosi: 8'hFF};
    vecs[2] = '{tx: 8'hC3, loop: 1'b1, pat: 8'h00, new_tx: 8'h00, exp_rx: 8'hC3, exp_mosi: 8'hC3};
    vecs[3] = '{tx: 8'h00, loop: 1'b0, pat: 8'hFF, new_tx: 8'h00, exp_rx: 8'hFF, exp_mosi: 8'h00};

    reset = 1'b1; start = 1'b0; tx_data = '0; loop_en = 1'b1; bus_bit = 1'b0;
    start1 = 1'b0; tx1 = '0;
    repeat (3) next_cycle();
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_cs", chip_select, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rx", rx_data, 8'h00);
    reset = 1'b0;
    next_cycle();

    foreach (vecs[i]) begin
      run_xfer(vecs[i]);
    end

    // start held high across the whole transfer: 0x11 then 0x22.
    loop_en = 1'b1;
    start   = 1'b1;
    tx_data = 8'h11;
    next_cycle();
    tx_data = 8'h22;
    done_cnt = 0; rises = 0; mosi_byte = '0; prev_sclk = 1'b0;
    for (int cyc = 1; cyc <= 72; cyc++) begin
      if (done) done_cnt++;
      if (sclk && !prev_sclk) begin rises++; mosi_byte = {mosi_byte[6:0], mosi}; end
      prev_sclk = sclk;
      next_cycle();
    end
    check("held_first_done_count", done_cnt, 1);
    check("held_first_mosi", mosi_byte, 8'h11);
    check("held_busy_low_c73", busy, 1'b0);
    check("held_cs_high_c73", chip_select, 1'b1);
    next_cycle();
    start = 1'b0;
    check("held_cs_low_c74", chip_select, 1'b0);
    check("held_busy_c74", busy, 1'b1);
    done_cnt = 0; done_cyc = -1; mosi_byte = '0; prev_sclk = 1'b0;
    for (int cyc = 74; cyc <= 150; cyc++) begin
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (sclk && !prev_sclk) mosi_byte = {mosi_byte[6:0], mosi};
      prev_sclk = sclk;
      next_cycle();
    end
    check("held_second_done_count", done_cnt, 1);
    check("held_second_done_cycle", done_cyc, 142);
    check("held_second_mosi", mosi_byte, 8'h22);
    check("held_second_rx", rx_data, 8'h22);

    // Reset at cycle 30 of a transfer.
    start   = 1'b1;
    tx_data = 8'hA5;
    next_cycle();
    start = 1'b0;
    done_cnt = 0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (done) done_cnt++;
      next_cycle();
    end
    check("rst_cs_low_before", chip_select, 1'b0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("rst_cs", chip_select, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx", rx_data, 8'h00);
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done) done_cnt++;
      next_cycle();
    end
    check("rst_no_done", done_cnt, 0);
    run_xfer('{tx: 8'h5A, loop: 1'b1, pat: 8'h00, new_tx: 8'h5A, exp_rx: 8'h5A, exp_mosi: 8'h5A});

    // HALF_PERIOD = 1 instance, loopback of 0x81.
    start1 = 1'b1;
    tx1    = 8'h81;
    next_cycle();
    start1 = 1'b0;
    done_cnt = 0; done_cyc = -1; bad_tog = 0; busy_fall = -1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (done1) begin done_cnt++; done_cyc = cyc; end
      if (!busy1 && busy_fall < 0) busy_fall = cyc;
      if (cyc >= 2 && cyc <= 17 && sclk1 !== ((cyc % 2) == 0)) bad_tog++;
      next_cycle();
    end
    check("h1_done_count", done_cnt, 1);
    check("h1_done_cycle", done_cyc, 18);
    check("h1_rx", rx1, 8'h81);
    check("h1_sclk_toggle_errors", bad_tog, 0);
    check("h1_busy_fall", busy_fall, 19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
